axi_lite_ctrl_bank: RTL

//  Parametrised AXI4-Lite slave register bank for N_CH accelerator channels (successor to the single-channel controller).

---
 rtl/axi_ctrl_pkg.sv | 22 ++
 rtl/axi_ctrl_chan_stat.sv | 48 ++++
 rtl/axi_lite_ctrl_bank.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ctrl_pkg.sv
// Shared definitions for the AXI4-Lite channel control bank:
// register offsets, response codes and the address-map check.
package axi_ctrl_pkg;

    // Byte offsets of the fixed registers; parameter registers follow OFF_PARAM0.
    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_STATUS = 32'h04;
    localparam logic [31:0] OFF_IRQ_EN = 32'h08;
    localparam logic [31:0] OFF_ID     = 32'h0C;
    localparam logic [31:0] OFF_PARAM0 = 32'h10;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    // A word-aligned offset is mapped when it falls below the end of the parameter block.
    function automatic logic addr_valid(input logic [31:0] offset, input int n_param);
        return offset < (OFF_PARAM0 + (32'(n_param) << 2));
    endfunction

endpackage

// File: rtl/axi_ctrl_chan_stat.sv
// Per-channel status slice: sticky DONE with set-over-clear priority,
// GO pulse gated by the BUSY level sampled at commit, and the IRQ term.
module axi_ctrl_chan_stat
    import axi_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic done_i,
    input  logic busy_i,
    input  logic go_req_i,
    input  logic clr_i,
    input  logic irq_en_i,
    output logic go_o,
    output logic done_o,
    output logic irq_term_o
);

    logic go_q;
    logic done_q;
    logic done_d;

    // A new completion in the same cycle as a W1C keeps the flag set.
    always_comb begin
        done_d = done_q;
        if (clr_i) begin
            done_d = 1'b0;
        end
        if (done_i) begin
            done_d = 1'b1;
        end
    end

    // GO is a single-cycle pulse; a busy channel swallows the request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            go_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            go_q   <= go_req_i & ~busy_i;
            done_q <= done_d;
        end
    end

    assign go_o       = go_q;
    assign done_o     = done_q;
    assign irq_term_o = done_q & irq_en_i;

endmodule

// File: rtl/axi_lite_ctrl_bank.sv
// AXI4-Lite slave register bank for N_CH accelerator channels.
// AW and W are captured into independent holding registers; a write commits
// once both are full and the B slot is free. Reads are registered one cycle.
// Optional feature macro: AXI_CTRL_IRQ_EN adds the IRQ_EN register and USER_IRQ.
module axi_lite_ctrl_bank
    import axi_ctrl_pkg::*;
#(
    parameter int          N_CH    = 4,
    parameter int          N_PARAM = 8,
    parameter int          ADDR_W  = 6,
    parameter logic [31:0] ID_VAL  = 32'h5354_0002
) (
    input  logic                   AXI_CTRL_ACLK,
    input  logic                   AXI_CTRL_ARESETN,
    input  logic [ADDR_W-1:0]      AXI_CTRL_AWADDR,
    input  logic [2:0]             AXI_CTRL_AWPROT,
    input  logic                   AXI_CTRL_AWVALID,
    output logic                   AXI_CTRL_AWREADY,
    input  logic [31:0]            AXI_CTRL_WDATA,
    input  logic [3:0]             AXI_CTRL_WSTRB,
    input  logic                   AXI_CTRL_WVALID,
    output logic                   AXI_CTRL_WREADY,
    output logic [1:0]             AXI_CTRL_BRESP,
    output logic                   AXI_CTRL_BVALID,
    input  logic                   AXI_CTRL_BREADY,
    input  logic [ADDR_W-1:0]      AXI_CTRL_ARADDR,
    input  logic [2:0]             AXI_CTRL_ARPROT,
    input  logic                   AXI_CTRL_ARVALID,
    output logic                   AXI_CTRL_ARREADY,
    output logic [31:0]            AXI_CTRL_RDATA,
    output logic [1:0]             AXI_CTRL_RRESP,
    output logic                   AXI_CTRL_RVALID,
    input  logic                   AXI_CTRL_RREADY,
    output logic [N_PARAM*32-1:0]  USER_PARAM,
    output logic [N_CH-1:0]        USER_GO,
    input  logic [N_CH-1:0]        USER_BUSY,
    input  logic [N_CH-1:0]        USER_DONE
`ifdef AXI_CTRL_IRQ_EN
    ,
    output logic                   USER_IRQ
`endif
);

    // Handshake rule on every channel: a transfer happens on a rising clock
    // edge where VALID and READY are both high; VALID, once raised, holds its
    // payload stable until that edge.

    logic               live_q;
    logic               aw_full_q;
    logic [ADDR_W-3:0]  aw_word_q;
    logic               w_full_q;
    logic [31:0]        w_data_q;
    logic [3:0]         w_strb_q;
    logic               bvalid_q;
    resp_t              bresp_q;
    logic               rvalid_q;
    logic [31:0]        rdata_q;
    resp_t              rresp_q;
    logic [31:0]        param_q [N_PARAM];

    logic               aw_hs;
    logic               w_hs;
    logic               ar_hs;
    logic               commit;
    logic [31:0]        w_off;
    logic [31:0]        r_off;
    resp_t              wr_resp;
    logic [31:0]        rd_val;
    resp_t              rd_resp;
    logic [N_CH-1:0]    go_req;
    logic [N_CH-1:0]    clr_req;
    logic [N_CH-1:0]    done_vec;
    logic [N_CH-1:0]    irq_term;
    logic [N_CH-1:0]    irq_en_vec;

    assign AXI_CTRL_AWREADY = live_q & ~aw_full_q;
    assign AXI_CTRL_WREADY  = live_q & ~w_full_q;
    assign AXI_CTRL_ARREADY = live_q & (~rvalid_q | AXI_CTRL_RREADY);
    assign AXI_CTRL_BVALID  = bvalid_q;
    assign AXI_CTRL_BRESP   = bresp_q;
    assign AXI_CTRL_RVALID  = rvalid_q;
    assign AXI_CTRL_RDATA   = rdata_q;
    assign AXI_CTRL_RRESP   = rresp_q;

    assign aw_hs  = AXI_CTRL_AWVALID & AXI_CTRL_AWREADY;
    assign w_hs   = AXI_CTRL_WVALID & AXI_CTRL_WREADY;
    assign ar_hs  = AXI_CTRL_ARVALID & AXI_CTRL_ARREADY;
    assign commit = aw_full_q & w_full_q & (~bvalid_q | AXI_CTRL_BREADY);

    assign w_off   = 32'(aw_word_q) << 2;
    assign r_off   = 32'(AXI_CTRL_ARADDR[ADDR_W-1:2]) << 2;
    assign wr_resp = addr_valid(w_off, N_PARAM) ? RESP_OKAY : RESP_SLVERR;
    assign go_req  = (commit && w_off == OFF_CTRL)   ? w_data_q[N_CH-1:0] : '0;
    assign clr_req = (commit && w_off == OFF_STATUS) ? w_data_q[N_CH-1:0] : '0;

    // Ready outputs stay low in reset and for the first cycle after it.
    always_ff @(posedge AXI_CTRL_ACLK) begin
        if (!AXI_CTRL_ARESETN) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // Independent AW/W holding registers plus the B response slot.
    always_ff @(posedge AXI_CTRL_ACLK) begin
        if (!AXI_CTRL_ARESETN) begin
            aw_full_q <= 1'b0;
            aw_word_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_word_q <= AXI_CTRL_AWADDR[ADDR_W-1:2];
            end else if (commit) begin
                aw_full_q <= 1'b0;
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= AXI_CTRL_WDATA;
                w_strb_q <= AXI_CTRL_WSTRB;
            end else if (commit) begin
                w_full_q <= 1'b0;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (AXI_CTRL_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Byte-strobed parameter registers, updated at commit.
    always_ff @(posedge AXI_CTRL_ACLK) begin
        if (!AXI_CTRL_ARESETN) begin
            param_q <= '{default: '0};
        end else if (commit) begin
            for (int i = 0; i < N_PARAM; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_off == (OFF_PARAM0 + (32'(i) << 2)) && w_strb_q[b]) begin
                        param_q[i][8*b +: 8] <= w_data_q[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read decode from current state, so a same-cycle write is not yet visible.
    always_comb begin
        rd_val  = '0;
        rd_resp = RESP_OKAY;
        if (!addr_valid(r_off, N_PARAM)) begin
            rd_resp = RESP_SLVERR;
        end else if (r_off == OFF_STATUS) begin
            rd_val[N_CH-1:0]   = done_vec;
            rd_val[16 +: N_CH] = USER_BUSY;
        end else if (r_off == OFF_IRQ_EN) begin
            rd_val[N_CH-1:0] = irq_en_vec;
        end else if (r_off == OFF_ID) begin
            rd_val = ID_VAL;
        end else begin
            for (int i = 0; i < N_PARAM; i++) begin
                if (r_off == (OFF_PARAM0 + (32'(i) << 2))) begin
                    rd_val = param_q[i];
                end
            end
        end
    end

    // R slot: loaded on AR handshake, held until RREADY.
    always_ff @(posedge AXI_CTRL_ACLK) begin
        if (!AXI_CTRL_ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_val;
            rresp_q  <= rd_resp;
        end else if (AXI_CTRL_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        axi_ctrl_chan_stat u_stat (
            .clk_i      (AXI_CTRL_ACLK),
            .rst_ni     (AXI_CTRL_ARESETN),
            .done_i     (USER_DONE[c]),
            .busy_i     (USER_BUSY[c]),
            .go_req_i   (go_req[c]),
            .clr_i      (clr_req[c]),
            .irq_en_i   (irq_en_vec[c]),
            .go_o       (USER_GO[c]),
            .done_o     (done_vec[c]),
            .irq_term_o (irq_term[c])
        );
    end

    for (genvar i = 0; i < N_PARAM; i++) begin : g_param
        assign USER_PARAM[32*i +: 32] = param_q[i];
    end

`ifdef AXI_CTRL_IRQ_EN
    logic [N_CH-1:0] irq_en_q;
    logic            irq_q;

    // IRQ enable register and the registered interrupt OR.
    always_ff @(posedge AXI_CTRL_ACLK) begin
        if (!AXI_CTRL_ARESETN) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (commit && w_off == OFF_IRQ_EN) begin
                irq_en_q <= w_data_q[N_CH-1:0];
            end
            irq_q <= |irq_term;
        end
    end

    assign irq_en_vec = irq_en_q;
    assign USER_IRQ   = irq_q;
`else
    assign irq_en_vec = '0;

    logic unused_irq;
    assign unused_irq = ^irq_term;
`endif

    logic unused_ok;
    assign unused_ok = ^{AXI_CTRL_AWPROT, AXI_CTRL_ARPROT,
                         AXI_CTRL_AWADDR[1:0], AXI_CTRL_ARADDR[1:0]};

endmodule
